// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: trigger-driven capture of retired {pc, inst} records from the
// WB-stage tracer bus into a circular buffer, then readout over a valid/ready port.
// Purely observational: it never back-pressures the core.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   wb_trace[63:0]      WB trace record, packed as {pc[63:32], inst[31:0]}
//   wb_retire           wb_trace holds a retiring instruction this cycle
//   arm / abort         pulses: start a fresh capture / discard and go idle
//   trig_pc, post_cnt   trigger address and post-trigger retire count (sampled on arm)
//   trig_occ[7:0]       (TRACE_TRIG_OCC_EN only) fire on the Nth match, 0 means 1
//   busy, triggered     capture in progress / trigger fired in current capture
//   rd_valid/rd_ready   readout handshake; rd_pc, rd_inst, rd_last carry the entry
//   fill                valid entries held (0..DEPTH)
//
// Build option: define TRACE_TRIG_OCC_EN to add the trig_occ occurrence-count trigger.
module trace_capture_ctrl #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned XLEN  = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [XLEN+31:0]  wb_trace,
  input  logic              wb_retire,
  input  logic              arm,
  input  logic              abort,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic [PTR_W-1:0]  post_cnt,
`ifdef TRACE_TRIG_OCC_EN
  input  logic [7:0]        trig_occ,
`endif
  output logic              busy,
  output logic              triggered,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [XLEN-1:0]   rd_pc,
  output logic [31:0]       rd_inst,
  output logic              rd_last,
  output logic [PTR_W:0]    fill
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    fill_d;
  logic [PTR_W-1:0]  remain_q, remain_d;
  logic [PTR_W-1:0]  post_q, post_d;
  logic [XLEN-1:0]   trig_pc_q, trig_pc_d;
  logic              triggered_d, busy_d, rd_valid_d, rd_last_d;
  logic              wr_en, pc_hit, fire;

  logic [XLEN-1:0]   mem_pc   [DEPTH];
  logic [31:0]       mem_inst [DEPTH];

  assign pc_hit = (wb_trace[XLEN+31:32] == trig_pc_q);

`ifdef TRACE_TRIG_OCC_EN
  logic [7:0] occ_q, occ_d, occ_tgt_q, occ_tgt_d;
  // Fire when this match is the target occurrence.
  assign fire = pc_hit && (8'(occ_q + 8'd1) == occ_tgt_q);
`else
  assign fire = pc_hit;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill;
    remain_d    = remain_q;
    post_d      = post_q;
    trig_pc_d   = trig_pc_q;
    triggered_d = triggered;
    wr_en       = 1'b0;
`ifdef TRACE_TRIG_OCC_EN
    occ_d       = occ_q;
    occ_tgt_d   = occ_tgt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d     = S_ARMED;
          wr_ptr_d    = '0;
          fill_d      = '0;
          triggered_d = 1'b0;
          trig_pc_d   = trig_pc;
          // post_cnt is PTR_W wide, so it can never exceed DEPTH-1 and the
          // trigger entry always survives the post window.
          post_d      = post_cnt;
`ifdef TRACE_TRIG_OCC_EN
          occ_d       = 8'd0;
          occ_tgt_d   = (trig_occ == 8'd0) ? 8'd1 : trig_occ;
`endif
        end
      end
      S_ARMED, S_POST: begin
        if (wb_retire) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          fill_d   = (fill == FULL) ? FULL : fill + (PTR_W+1)'(1);
          if (state_q == S_ARMED) begin
`ifdef TRACE_TRIG_OCC_EN
            if (pc_hit) occ_d = 8'(occ_q + 8'd1);
`endif
            if (fire) begin
              triggered_d = 1'b1;
              remain_d    = post_q;
              state_d     = (post_q == '0) ? S_DRAIN : S_POST;
            end
          end else begin
            remain_d = remain_q - PTR_W'(1);
            if (remain_q == PTR_W'(1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (rd_valid && rd_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          fill_d   = fill - (PTR_W+1)'(1);
          if (fill == (PTR_W+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // On DRAIN entry point at the oldest entry; a full buffer has wrapped.
    if (state_q != S_DRAIN && state_d == S_DRAIN)
      rd_ptr_d = (fill_d == FULL) ? wr_ptr_d : '0;

    // abort wins over arm and over a same-cycle capture write.
    if (abort) begin
      state_d     = S_IDLE;
      fill_d      = '0;
      triggered_d = 1'b0;
      wr_en       = 1'b0;
`ifdef TRACE_TRIG_OCC_EN
      occ_d       = 8'd0;
`endif
    end

    busy_d     = (state_d == S_ARMED) || (state_d == S_POST);
    rd_valid_d = (state_d == S_DRAIN) && (fill_d != '0);
    rd_last_d  = (state_d == S_DRAIN) && (fill_d == (PTR_W+1)'(1));
  end

  // State and registered outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill      <= '0;
      remain_q  <= '0;
      post_q    <= '0;
      trig_pc_q <= '0;
      triggered <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
`ifdef TRACE_TRIG_OCC_EN
      occ_q     <= 8'd0;
      occ_tgt_q <= 8'd1;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill      <= fill_d;
      remain_q  <= remain_d;
      post_q    <= post_d;
      trig_pc_q <= trig_pc_d;
      triggered <= triggered_d;
      busy      <= busy_d;
      rd_valid  <= rd_valid_d;
      rd_last   <= rd_last_d;
`ifdef TRACE_TRIG_OCC_EN
      occ_q     <= occ_d;
      occ_tgt_q <= occ_tgt_d;
`endif
    end
  end

  // Capture buffer; contents are don't-care after reset.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]   <= wb_trace[XLEN+31:32];
      mem_inst[wr_ptr_q] <= wb_trace[31:0];
    end
  end

  // Readout data follows rd_ptr directly; zero when nothing is offered.
  assign rd_pc   = rd_valid ? mem_pc[rd_ptr_q]   : '0;
  assign rd_inst = rd_valid ? mem_inst[rd_ptr_q] : '0;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl (DEPTH=16): table-driven capture
// scenarios plus hand-written back-pressure, abort, DRAIN-arm and reset sequences.
module tb_trace_capture_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [63:0] wb_trace;
  logic        wb_retire, arm, abort, rd_ready;
  logic [31:0] trig_pc;
  logic [3:0]  post_cnt;
`ifdef TRACE_TRIG_OCC_EN
  logic [7:0]  trig_occ;
`endif
  logic        busy, triggered, rd_valid, rd_last;
  logic [31:0] rd_pc, rd_inst;
  logic [4:0]  fill;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  trace_capture_ctrl #(.DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .wb_trace(wb_trace), .wb_retire(wb_retire),
    .arm(arm), .abort(abort), .trig_pc(trig_pc), .post_cnt(post_cnt),
`ifdef TRACE_TRIG_OCC_EN
    .trig_occ(trig_occ),
`endif
    .busy(busy), .triggered(triggered), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_last(rd_last), .fill(fill)
  );

  typedef struct {
    logic [31:0] trig;
    logic [3:0]  post;
    logic [7:0]  occ;
    logic        arm_ret;   // also retire pc=trig on the arm cycle
    int          mode;      // 0: linear pcs, 1: three-instruction loop
    logic [31:0] first;
    int          nret;      // retire budget
    int          exp_nwr;   // retires until DRAIN
    int          exp_cnt;   // fill at DRAIN
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } cap_vec_t;

  cap_vec_t vecs[6];
  int       nvec;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_0013;
  endfunction

  function automatic logic [31:0] pc_at(input int mode, input logic [31:0] first, input int i);
    if (mode == 1) return first + 32'(4 * (i % 3));
    return first + 32'(4 * i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, sample 1ns after the following posedge.
  task automatic step(input logic a, input logic ab, input logic r,
                      input logic [31:0] pc, input logic rdy);
    @(negedge ACLK);
    arm = a; abort = ab; wb_retire = r; rd_ready = rdy;
    wb_trace = {pc, inst_of(pc)};
    @(posedge ACLK);
    #1;
  endtask

  task automatic setup(input logic [31:0] t, input logic [3:0] p, input logic [7:0] o);
    trig_pc = t; post_cnt = p;
`ifdef TRACE_TRIG_OCC_EN
    trig_occ = o;
`else
    if (o != 8'd0) $display("note: occurrence count %0d unused in this build", o);
`endif
  endtask

  task automatic run_capture(input cap_vec_t v);
    logic [31:0] q[$];
    logic [31:0] epc;
    bit drained;
    int base;
    setup(v.trig, v.post, v.occ);
    step(1'b1, 1'b0, v.arm_ret, v.trig, 1'b0);
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_fill", 32'(fill), 32'd0);
    check("arm_trig", 32'(triggered), 32'd0);
    drained = 1'b0;
    for (int i = 0; i < v.nret; i++) begin
      q.push_back(pc_at(v.mode, v.first, i));
      step(1'b0, 1'b0, 1'b1, pc_at(v.mode, v.first, i), 1'b0);
      if (rd_valid) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain_reached", 32'(drained), 32'd1);
    if (!drained) return;
    check("drain_nwr", 32'(q.size()), 32'(v.exp_nwr));
    check("drain_fill", 32'(fill), 32'(v.exp_cnt));
    check("drain_trig", 32'(triggered), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);
    if (q.size() < v.exp_cnt) return;
    base = q.size() - v.exp_cnt;
    for (int k = 0; k < v.exp_cnt; k++) begin
      epc = q[base + k];
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_pc", rd_pc, epc);
      check("rd_inst", rd_inst, inst_of(epc));
      check("rd_last", 32'(rd_last), (k == v.exp_cnt - 1) ? 32'd1 : 32'd0);
      check("rd_fill", 32'(fill), 32'(v.exp_cnt - k));
      if (k == 0) check("rd_first_pc", rd_pc, v.exp_first);
      if (k == v.exp_cnt - 1) check("rd_last_pc", rd_pc, v.exp_last);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_fill", 32'(fill), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_trig_hold", 32'(triggered), 32'd1);
    check("idle_rd_pc", rd_pc, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_trig"}, 32'(triggered), 32'd0);
    check({tag, "_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_last"}, 32'(rd_last), 32'd0);
    check({tag, "_fill"}, 32'(fill), 32'd0);
    check({tag, "_pc"}, rd_pc, 32'd0);
    check({tag, "_inst"}, rd_inst, 32'd0);
  endtask

  initial begin
    logic       rdy_pat [4];
    logic [4:0] fill_pat[4];
    logic [31:0] pc_pat [4];

    //          trig        post  occ  aret mode first       nret nwr cnt first      last
    vecs[0] = '{32'h100,    4'd3,  8'd0, 1'b0, 0, 32'h0F0,    20,  8,  8, 32'h0F0,  32'h10C};
    vecs[1] = '{32'h200,    4'd2,  8'd0, 1'b0, 0, 32'h188,    40, 33, 16, 32'h1CC,  32'h208};
    vecs[2] = '{32'h080,    4'd0,  8'd0, 1'b0, 0, 32'h080,     4,  1,  1, 32'h080,  32'h080};
    vecs[3] = '{32'h300,    4'd15, 8'd0, 1'b0, 0, 32'h300,    24, 16, 16, 32'h300,  32'h33C};
    vecs[4] = '{32'h700,    4'd0,  8'd0, 1'b1, 0, 32'h6FC,     4,  2,  2, 32'h6FC,  32'h700};
    nvec = 5;
`ifdef TRACE_TRIG_OCC_EN
    vecs[5] = '{32'h040,    4'd2,  8'd3, 1'b0, 1, 32'h03C,    16, 10, 10, 32'h03C,  32'h03C};
    nvec = 6;
`else
    vecs[5] = vecs[0];
`endif
    rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    fill_pat = '{5'd7, 5'd7, 5'd7, 5'd6};
    pc_pat   = '{32'h0F4, 32'h0F4, 32'h0F4, 32'h0F8};

    ARESET = 1'b1; arm = 0; abort = 0; wb_retire = 0; rd_ready = 0;
    wb_trace = '0;
    setup(32'd0, 4'd0, 8'd0);
    #12;
    check_all_zero("reset");
    @(negedge ACLK);
    ARESET = 1'b0;

    for (int n = 0; n < nvec; n++) run_capture(vecs[n]);

    // Back-pressure: readout with rd_ready 1,0,0,1.
    setup(32'h100, 4'd3, 8'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 32'h0F0 + 32'(4 * i), 1'b0);
    check("bp_valid", 32'(rd_valid), 32'd1);
    check("bp_fill0", 32'(fill), 32'd8);
    check("bp_pc0", rd_pc, 32'h0F0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, rdy_pat[i]);
      check("bp_fill", 32'(fill), 32'(fill_pat[i]));
      check("bp_pc", rd_pc, pc_pat[i]);
      check("bp_inst", rd_inst, inst_of(pc_pat[i]));
    end
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("bp_abort_valid", 32'(rd_valid), 32'd0);
    check("bp_abort_fill", 32'(fill), 32'd0);
    check("bp_abort_trig", 32'(triggered), 32'd0);

    // Abort during POST with fill=5, colliding with a retire.
    setup(32'h500, 4'd5, 8'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'h4F0 + 32'(4 * i), 1'b0);
    check("post_fill", 32'(fill), 32'd5);
    check("post_busy", 32'(busy), 32'd1);
    check("post_trig", 32'(triggered), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h504, 1'b0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fill", 32'(fill), 32'd0);
    check("abort_valid", 32'(rd_valid), 32'd0);
    check("abort_trig", 32'(triggered), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("abort_stays_idle", 32'(busy), 32'd0);
    run_capture('{32'h600, 4'd1, 8'd0, 1'b0, 0, 32'h5F8, 8, 4, 4, 32'h5F8, 32'h604});

    // post_cnt=0 on the first retire, arm ignored in DRAIN, async reset mid-DRAIN.
    setup(32'h080, 4'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h080, 1'b0);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_last", 32'(rd_last), 32'd1);
    check("single_pc", rd_pc, 32'h080);
    setup(32'h999, 4'd2, 8'd0);
    step(1'b1, 1'b0, 1'b1, 32'h999, 1'b0);
    check("darm_valid", 32'(rd_valid), 32'd1);
    check("darm_fill", 32'(fill), 32'd1);
    check("darm_busy", 32'(busy), 32'd0);
    check("darm_pc", rd_pc, 32'h080);
    check("darm_trig", 32'(triggered), 32'd1);
    #3 ARESET = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge ACLK);
    ARESET = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
